// File: rtl/bch_pkg.sv
// Shared GF(2^4) definitions for the BCH(15,7) decoder.
// Field sizes, alpha power table, constant multiply helper, FSM states.
package bch_pkg;

  localparam int M = 4;
  localparam int N = 15;
  localparam logic [M:0] PRIM = 5'b10011;

  localparam logic [M-1:0] ALPHA [0:N-1] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hc, 4'hb,
    4'h5, 4'ha, 4'h7, 4'he, 4'hf, 4'hd, 4'h9
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic [M-1:0] alpha_pow(input logic [3:0] i);
    return ALPHA[i];
  endfunction

  // Shift-and-add multiply, reduced by x^4+x+1.
  function automatic logic [M-1:0] gf_mul(
    input logic [M-1:0] a,
    input logic [M-1:0] b
  );
    logic [M-1:0] p;
    logic [M-1:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) p = p ^ t;
      t = t[M-1] ? ((t << 1) ^ PRIM[M-1:0]) : (t << 1);
    end
    return p;
  endfunction

endpackage

// File: rtl/bch_chien_search_mul.sv
// Multiply a GF(2^4) value by the constant alpha^POW.
// Ports: a (operand), y (a * alpha^POW); folds to a fixed XOR network.
module gf16_mul_alpha_pow
  import bch_pkg::*;
#(
  parameter int POW = 1
) (
  input  logic [M-1:0] a,
  output logic [M-1:0] y
);

  assign y = gf_mul(a, alpha_pow(4'(POW)));

endmodule

// File: rtl/bch_chien_search.sv
// Chien search + correction for BCH(15,7): finds roots of 1+l1*x+l2*x^2.
// Ports: start/lambda1/lambda2/rx_word in; busy, done, err_vec, corrected, n_err, fail out.
module bch_chien_search
  import bch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] lambda1,
  input  logic [M-1:0] lambda2,
  input  logic [N-1:0] rx_word,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] err_vec,
  output logic [N-1:0] corrected,
  output logic [1:0]   n_err,
  output logic         fail
);

  state_t       state;
  logic [3:0]   j;
  logic [M-1:0] r1;
  logic [M-1:0] r2;
  logic [M-1:0] r1n;
  logic [M-1:0] r2n;
  logic [N-1:0] rx_q;
  logic [N-1:0] acc;
  logic [1:0]   deg;
  logic [1:0]   cnt;
  logic         ovf;
  logic         root;
  logic         bad;

  // r1 steps by alpha^-1, r2 by alpha^-2 per position
  gf16_mul_alpha_pow #(.POW(14)) u_mul1 (.a(r1), .y(r1n));
  gf16_mul_alpha_pow #(.POW(13)) u_mul2 (.a(r2), .y(r2n));

  assign root = (M'(1) ^ r1 ^ r2) == '0;
  assign bad  = ovf | (cnt != deg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      j         <= '0;
      r1        <= '0;
      r2        <= '0;
      rx_q      <= '0;
      acc       <= '0;
      deg       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_vec   <= '0;
      corrected <= '0;
      n_err     <= '0;
      fail      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            r1    <= lambda1;
            r2    <= lambda2;
            j     <= '0;
            rx_q  <= rx_word;
            deg   <= (lambda2 != '0) ? 2'd2 :
                     (lambda1 != '0) ? 2'd1 : 2'd0;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          if (root) begin
            acc[j] <= 1'b1;
            // a third root cannot be counted; remember it as failure
            if (cnt == 2'd2) ovf <= 1'b1;
            else cnt <= cnt + 2'd1;
          end
          r1 <= r1n;
          r2 <= r2n;
          j  <= j + 4'd1;
          if (j == 4'd14) state <= DONE;
        end
        DONE: begin
          err_vec   <= acc;
          n_err     <= cnt;
          fail      <= bad;
          corrected <= bad ? rx_q : (rx_q ^ acc);
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bch_chien_search.md
# bch_chien_search

Chien-search and correction stage of the BCH(15,7) double-error-correcting decoder over GF(2^4). It sits directly downstream of the Berlekamp–Massey block and consumes its error-locator coefficients lambda1 and lambda2. It evaluates Λ(x) = 1 + λ1·x + λ2·x² at α^-j for every bit position j = 0..14, one position per clock, and builds the error vector. At the end it flips the located bits of the latched received word, or flags an uncorrectable word.

## Interface
- M, 4, field width; GF(2^4), primitive polynomial x⁴+x+1; only 4 supported
- N, 15, codeword length = 2^M − 1
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request; samples lambda1, lambda2, rx_word; honoured only while busy=0
- lambda1  in  M  locator coefficient λ1 from BM stage
- lambda2  in  M  locator coefficient λ2 from BM stage
- rx_word  in  N  received word, bit j = coefficient of x^j
- busy  out  1  search in progress
- done  out  1  one-cycle pulse; results valid from this cycle
- err_vec  out  N  bit j set iff Λ(α^-j) = 0
- corrected  out  N  rx_word ^ err_vec, or rx_word unchanged when fail=1
- n_err  out  2  number of roots found (0..2)
- fail  out  1  root count ≠ deg Λ (uncorrectable)

## Operation
- Reset value of every output is 0. Internal state resets to IDLE. The position counter and the r1, r2 registers reset to 0.
- States:
  - IDLE: waits for start.
  - SEARCH: 15 cycles, j = 0..14.
  - DONE: one cycle, then returns to IDLE.
- IDLE & start:
  - r1 ← λ1, r2 ← λ2, j ← 0.
  - Latch rx_word and deg, where deg = 2 if λ2 ≠ 0, else 1 if λ1 ≠ 0, else 0.
  - Clear the err_vec accumulator and the root count.
  - Go to SEARCH.
- SEARCH, each cycle:
  - root = (1 ^ r1 ^ r2) == 0. If root, set acc[j] and increment the count.
  - r1 ← r1·α^14 (α^-1); r2 ← r2·α^13 (α^-2).
  - j ← j+1. After j = 14, go to DONE.
- DONE:
  - Register err_vec, n_err and fail = (count ≠ deg).
  - Register corrected as described in Interface.
  - Pulse done; return to IDLE.
- Outputs hold their values until the next DONE or a reset.
- Count saturates at 2. A third root is impossible by algebra, but if one occurs the block sets fail.
- start while busy=1 is ignored; there is no queueing.
- rst mid-search aborts immediately: no done pulse, all outputs 0.
- GF arithmetic: multiplication by a constant is a fixed XOR network. Addition is XOR. No carries; all values are M bits.

## Timing
- start sampled at edge k; busy = 1 from after edge k until after edge k+16.
- Position j is evaluated in the cycle after edge k+j and recorded at edge k+j+1.
- done, err_vec, corrected, n_err and fail update at edge k+16; done is high for exactly that one cycle.
- A new start is accepted from the cycle after done, i.e. sampled at edge k+17 at the earliest.
- Throughput: one word per 17 cycles.

## Structure
- Package bch_pkg holds:
  - M, N and the primitive polynomial;
  - the α^i power table;
  - a gf_mul function;
  - the state enum (IDLE, SEARCH, DONE).
- Sub-module gf16_mul_alpha_pow (parameter POW) implements the constant-α-power multiplier. It is instantiated twice: POW=14 for r1 and POW=13 for r2.

## Test plan
- Single error:
  - Stimulus: λ1 = 4'b1000 (α³), λ2 = 0, rx_word = 15'h0000.
  - Response: err_vec = 15'h0008, corrected = 15'h0008, n_err = 1, fail = 0, done at start+16.
- Double error:
  - Stimulus: λ1 = 4'b0010 (α), λ2 = 4'b1011 (α⁷), rx_word = 15'h7FFF.
  - Response: err_vec = 15'h0024, corrected = 15'h7FDB, n_err = 2, fail = 0.
- No error:
  - Stimulus: λ1 = λ2 = 0, rx_word = 15'h1234.
  - Response: err_vec = 0, corrected = 15'h1234, n_err = 0, fail = 0.
- Uncorrectable:
  - Stimulus: λ1 = 0, λ2 = 4'b0010, rx_word = 15'h00FF.
  - Response: single root at j = 8, so err_vec = 15'h0100, n_err = 1, fail = 1, corrected = 15'h00FF.
- Busy and reset:
  - Stimulus: start again at start+5.
  - Response: ignored; done comes only at start+16.
  - Stimulus: new run, then assert rst at start+7.
  - Response: outputs go to 0 immediately; no done pulse.
- Back-to-back:
  - Stimulus: start at start+17 after a prior done.
  - Response: accepted; the second result matches its own vector.
